shift_add_mult_4x4: RTL



---
 rtl/shift_add_mult_4x4.sv | 112 +++++++++++
 1 files changed

// File: rtl/shift_add_mult_4x4.sv
// Sequential 4x4 unsigned shift-add multiplier built around a single 4-bit ripple-carry adder.
// Retires one multiplier bit per clock and reports the 8-bit product with a start/done handshake.

module rca_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    always_comb begin
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

module shift_add_mult_4x4 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] product,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] m_q, m_d;
    logic [3:0] q_q, q_d;
    logic [3:0] a_q, a_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] product_q, product_d;

    logic [3:0] add_b;
    logic [3:0] add_sum;
    logic       add_cout;

    assign add_b = q_q[0] ? m_q : 4'b0000;

    rca_4_bit u_rca (
        .a    (a_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The carry register C is always zero after the right shift, because cout
    // lands in A's MSB; it therefore needs no flop of its own.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    a_d     = 4'd0;
                    cnt_d   = 3'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d   = {add_cout, add_sum[3:1]};
                q_d   = {add_sum[0], q_q[3:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd3) begin
                    product_d = {add_cout, add_sum, q_q[3:1]};
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            q_q       <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            a_q       <= a_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
endmodule
